// File: rtl/exception_sequencer.sv
// Exception entry sequencer: saves EPC, fetches the handler byte from the vector
// table and steers the PC mux to it, stalling the main control unit throughout.
module exception_sequencer #(
    parameter int          MEM_LAT    = 1,
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_rdata,
    output logic        cpu_stall,
    output logic        mem_sel,
    output logic [31:0] mem_addr,
    output logic        epc_write,
    output logic [31:0] epc_value,
    output logic [1:0]  ex_control,
    output logic [31:0] handler_addr,
    output logic        pc_write,
    output logic [1:0]  cause
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SAVE = 2'd1,
        S_WAIT = 2'd2,
        S_LOAD = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     vec_q, vec_d;
    logic [31:0]     epc_q, epc_d;
    logic [7:0]      handler_q, handler_d;
    logic [1:0]      cause_q, cause_d;

    // Only the low byte of the vector entry is the handler address.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata[31:8];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vec_d     = vec_q;
        epc_d     = epc_q;
        handler_d = handler_q;
        cause_d   = cause_q;
        case (state_q)
            S_IDLE: begin
                if (exc_opcode || exc_overflow || exc_div0) begin
                    if (exc_opcode) begin
                        cause_d = 2'b01;
                        vec_d   = VEC_OPCODE;
                    end else if (exc_overflow) begin
                        cause_d = 2'b10;
                        vec_d   = VEC_OVF;
                    end else begin
                        cause_d = 2'b11;
                        vec_d   = VEC_DIV0;
                    end
                    epc_d   = pc_in - 32'd4;
                    state_d = S_SAVE;
                end
            end
            S_SAVE: begin
                cnt_d   = CW'(MEM_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    handler_d = mem_rdata[7:0];
                    state_d   = S_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            vec_q     <= '0;
            epc_q     <= '0;
            handler_q <= '0;
            cause_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vec_q     <= vec_d;
            epc_q     <= epc_d;
            handler_q <= handler_d;
            cause_q   <= cause_d;
        end
    end

    // Outputs are registers or pure state decodes; no input reaches them combinationally.
    assign cpu_stall    = (state_q != S_IDLE);
    assign mem_sel      = (state_q == S_SAVE) || (state_q == S_WAIT);
    assign mem_addr     = vec_q;
    assign epc_write    = (state_q == S_SAVE);
    assign epc_value    = epc_q;
    assign ex_control   = {1'b0, (state_q == S_LOAD)};
    assign handler_addr = {24'b0, handler_q};
    assign pc_write     = (state_q == S_LOAD);
    assign cause        = cause_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each fed from a small vector-table memory model.
module tb_exception_sequencer;

  logic        clk;
  logic        reset_n;
  logic        exc_opcode, exc_overflow, exc_div0;
  logic        e3_opcode, e3_overflow, e3_div0;
  logic [31:0] pc_in;
  logic [31:0] rdata1, rdata3;
  logic [31:0] vec_mem [256];

  logic        o1_stall, o1_sel, o1_epcw, o1_pcw;
  logic [31:0] o1_addr, o1_epcv, o1_h;
  logic [1:0]  o1_exc, o1_cause;
  logic        o3_stall, o3_sel, o3_epcw, o3_pcw;
  logic [31:0] o3_addr, o3_epcv, o3_h;
  logic [1:0]  o3_exc, o3_cause;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // observations collected by run_seq
  int          obs_stall, obs_pw_cnt, obs_pw_cyc, obs_ew_cnt, obs_sel_first, obs_sel_last;
  logic        obs_done;
  logic [31:0] obs_epc, obs_addr1, obs_pw_h;
  logic [1:0]  obs_pw_cause, obs_pw_exc;

  exception_sequencer #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_in(pc_in), .mem_rdata(rdata1),
    .cpu_stall(o1_stall), .mem_sel(o1_sel), .mem_addr(o1_addr),
    .epc_write(o1_epcw), .epc_value(o1_epcv), .ex_control(o1_exc),
    .handler_addr(o1_h), .pc_write(o1_pcw), .cause(o1_cause)
  );

  exception_sequencer #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .exc_opcode(e3_opcode), .exc_overflow(e3_overflow), .exc_div0(e3_div0),
    .pc_in(pc_in), .mem_rdata(rdata3),
    .cpu_stall(o3_stall), .mem_sel(o3_sel), .mem_addr(o3_addr),
    .epc_write(o3_epcw), .epc_value(o3_epcv), .ex_control(o3_exc),
    .handler_addr(o3_h), .pc_write(o3_pcw), .cause(o3_cause)
  );

  always_comb begin
    rdata1 = vec_mem[o1_addr[7:0]];
    rdata3 = vec_mem[o3_addr[7:0]];
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // driver + monitor: fires one exception and records what the DUT does
  task automatic run_seq(input logic use3, input logic [2:0] exc, input int div0_cyc);
    logic        st, sl, ew, pw;
    logic [31:0] ad, ev, h;
    logic [1:0]  xc, ca;
    obs_stall = 0; obs_pw_cnt = 0; obs_pw_cyc = 0; obs_ew_cnt = 0;
    obs_sel_first = 0; obs_sel_last = 0; obs_done = 1'b0;
    obs_epc = '0; obs_addr1 = '0; obs_pw_h = '0; obs_pw_cause = '0; obs_pw_exc = '0;
    if (use3) {e3_opcode, e3_overflow, e3_div0} = exc;
    else      {exc_opcode, exc_overflow, exc_div0} = exc;
    next_cycle();
    {exc_opcode, exc_overflow, exc_div0} = 3'b000;
    {e3_opcode, e3_overflow, e3_div0} = 3'b000;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (!use3) exc_div0 = (cyc == div0_cyc);
      st = use3 ? o3_stall : o1_stall;
      sl = use3 ? o3_sel   : o1_sel;
      ew = use3 ? o3_epcw  : o1_epcw;
      pw = use3 ? o3_pcw   : o1_pcw;
      ad = use3 ? o3_addr  : o1_addr;
      ev = use3 ? o3_epcv  : o1_epcv;
      h  = use3 ? o3_h     : o1_h;
      xc = use3 ? o3_exc   : o1_exc;
      ca = use3 ? o3_cause : o1_cause;
      if (cyc == 1) begin
        obs_epc   = ev;
        obs_addr1 = ad;
      end
      if (st) obs_stall++;
      if (sl) begin
        if (obs_sel_first == 0) obs_sel_first = cyc;
        obs_sel_last = cyc;
      end
      if (ew) obs_ew_cnt++;
      if (pw) begin
        obs_pw_cnt++;
        obs_pw_cyc   = cyc;
        obs_pw_h     = h;
        obs_pw_cause = ca;
        obs_pw_exc   = xc;
      end
      if (!st) begin
        obs_done = 1'b1;
        break;
      end
      next_cycle();
    end
    exc_div0 = 1'b0;
  endtask

  // scoreboard pop: compares the handler seen at pc_write to the queued value
  task automatic sb_pop(input string name);
    logic [31:0] e;
    checks++;
    if (!obs_done) begin
      errors++;
      $display("FAIL %s_timeout: sequence did not return to IDLE within bound", name);
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: expected queue empty", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (obs_pw_cnt == 0 || obs_pw_h !== e) begin
        errors++;
        $display("FAIL %s_handler: got %h (pc_writes %0d) expected %h", name, obs_pw_h, obs_pw_cnt, e);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({o1_stall, o1_sel, o1_addr, o1_epcw, o1_epcv, o1_exc, o1_h, o1_pcw, o1_cause} !== '0) begin
      errors++;
      $display("FAIL reset_dut1: outputs not all zero stall=%b sel=%b addr=%h cause=%b", o1_stall, o1_sel, o1_addr, o1_cause);
    end
    checks++;
    if ({o3_stall, o3_sel, o3_addr, o3_epcw, o3_epcv, o3_exc, o3_h, o3_pcw, o3_cause} !== '0) begin
      errors++;
      $display("FAIL reset_dut3: outputs not all zero stall=%b sel=%b addr=%h cause=%b", o3_stall, o3_sel, o3_addr, o3_cause);
    end
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_overflow();
    pc_in = 32'h0000_0010;
    vec_mem[254] = 32'h0000_00A4;
    exp_q.push_back(32'hA4);
    run_seq(1'b0, 3'b010, 0);
    checks++; if (obs_epc !== 32'h0C) begin errors++; $display("FAIL ovf_epc: got %h expected %h", obs_epc, 32'h0C); end
    checks++; if (obs_addr1 !== 32'd254) begin errors++; $display("FAIL ovf_addr: got %0d expected 254", obs_addr1); end
    checks++; if (obs_ew_cnt !== 1) begin errors++; $display("FAIL ovf_epcw: got %0d pulses expected 1", obs_ew_cnt); end
    checks++; if (obs_pw_cyc !== 3) begin errors++; $display("FAIL ovf_pw_cyc: got %0d expected 3", obs_pw_cyc); end
    checks++; if (obs_pw_exc !== 2'b01) begin errors++; $display("FAIL ovf_exctl: got %b expected 01", obs_pw_exc); end
    checks++; if (obs_pw_cause !== 2'b10) begin errors++; $display("FAIL ovf_cause: got %b expected 10", obs_pw_cause); end
    checks++; if (obs_stall !== 3) begin errors++; $display("FAIL ovf_stall: got %0d expected 3", obs_stall); end
    checks++; if (obs_sel_first !== 1 || obs_sel_last !== 2) begin errors++; $display("FAIL ovf_sel: got %0d..%0d expected 1..2", obs_sel_first, obs_sel_last); end
    sb_pop("ovf");
  endtask

  task automatic test_simultaneous();
    pc_in = 32'h0000_0400;
    vec_mem[253] = 32'h0000_005C;
    exp_q.push_back(32'h5C);
    run_seq(1'b0, 3'b111, 0);
    checks++; if (obs_addr1 !== 32'd253) begin errors++; $display("FAIL sim_addr: got %0d expected 253", obs_addr1); end
    checks++; if (obs_pw_cause !== 2'b01) begin errors++; $display("FAIL sim_cause: got %b expected 01", obs_pw_cause); end
    checks++; if (obs_epc !== 32'h3FC) begin errors++; $display("FAIL sim_epc: got %h expected 3fc", obs_epc); end
    sb_pop("sim");
    // held outputs persist in IDLE
    checks++; if (o1_cause !== 2'b01 || o1_h !== 32'h5C) begin errors++; $display("FAIL sim_hold: cause %b handler %h expected 01 5c", o1_cause, o1_h); end
  endtask

  task automatic test_latency3();
    pc_in = 32'h0000_1000;
    vec_mem[255] = 32'h0000_007F;
    exp_q.push_back(32'h7F);
    run_seq(1'b1, 3'b001, 0);
    checks++; if (obs_sel_first !== 1 || obs_sel_last !== 4) begin errors++; $display("FAIL lat3_sel: got %0d..%0d expected 1..4", obs_sel_first, obs_sel_last); end
    checks++; if (obs_pw_cyc !== 5) begin errors++; $display("FAIL lat3_pw_cyc: got %0d expected 5", obs_pw_cyc); end
    checks++; if (obs_stall !== 5) begin errors++; $display("FAIL lat3_stall: got %0d expected 5", obs_stall); end
    checks++; if (obs_pw_cause !== 2'b11) begin errors++; $display("FAIL lat3_cause: got %b expected 11", obs_pw_cause); end
    checks++; if (obs_addr1 !== 32'd255) begin errors++; $display("FAIL lat3_addr: got %0d expected 255", obs_addr1); end
    sb_pop("lat3");
  endtask

  task automatic test_ignore_busy();
    int extra;
    pc_in = 32'h0000_0080;
    vec_mem[253] = 32'h0000_0033;
    exp_q.push_back(32'h33);
    run_seq(1'b0, 3'b100, 2);
    checks++; if (obs_pw_cnt !== 1) begin errors++; $display("FAIL busy_pw: got %0d pulses expected 1", obs_pw_cnt); end
    checks++; if (obs_pw_cause !== 2'b01) begin errors++; $display("FAIL busy_cause: got %b expected 01", obs_pw_cause); end
    sb_pop("busy");
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (o1_stall || o1_pcw) extra++;
      next_cycle();
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_second: got %0d busy cycles expected 0", extra); end
  endtask

  task automatic test_wrap();
    pc_in = 32'h0000_0000;
    vec_mem[254] = 32'hDEAD_BE12;
    exp_q.push_back(32'h12);
    run_seq(1'b0, 3'b010, 0);
    checks++; if (obs_epc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_epc: got %h expected fffffffc", obs_epc); end
    sb_pop("wrap");
  endtask

  task automatic test_reset_mid();
    int pw_seen;
    int busy;
    pc_in = 32'h0000_0200;
    exc_overflow = 1'b1;
    next_cycle();
    exc_overflow = 1'b0;
    next_cycle();
    checks++; if (!o1_sel || o1_epcw) begin errors++; $display("FAIL rmid_inwait: sel %b epcw %b expected 1 0", o1_sel, o1_epcw); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({o1_stall, o1_sel, o1_addr, o1_epcw, o1_epcv, o1_exc, o1_h, o1_pcw, o1_cause} !== '0) begin
      errors++;
      $display("FAIL rmid_zero: stall=%b sel=%b addr=%h pcw=%b cause=%b expected all 0", o1_stall, o1_sel, o1_addr, o1_pcw, o1_cause);
    end
    pw_seen = 0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      if (o1_pcw) pw_seen++;
    end
    reset_n = 1'b1;
    busy = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (o1_pcw) pw_seen++;
      if (o1_stall) busy++;
    end
    checks++; if (pw_seen !== 0) begin errors++; $display("FAIL rmid_pw: got %0d pc_write cycles expected 0", pw_seen); end
    checks++; if (busy !== 0) begin errors++; $display("FAIL rmid_idle: got %0d stall cycles expected 0", busy); end
  endtask

  initial begin
    reset_n = 1'b0;
    {exc_opcode, exc_overflow, exc_div0} = 3'b000;
    {e3_opcode, e3_overflow, e3_div0} = 3'b000;
    pc_in = '0;
    for (int i = 0; i < 256; i++) vec_mem[i] = {$urandom_range(0, 65535), $urandom_range(0, 65535)};
    test_reset();
    test_overflow();
    test_simultaneous();
    test_latency3();
    test_ignore_busy();
    test_wrap();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries remain expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
